if_fetch2: RTL

- Dual-issue instruction fetch stage directly upstream of the instruction buffer.
- Owns the PC and issues 8-byte-aligned fetch requests to instruction memory.
- Splits each 64-bit response into up to two instruction slots, each carrying inst/pc/npc.
- Honours the buffer's full back-pressure, the global stop, and branch redirects from the back end.

---
 rtl/if_fetch2.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch2.sv
// Dual-issue fetch: owns the PC and issues 8B-aligned requests. Each 64-bit response becomes up to two slots.
// Latency: a response reaches the output regs on the edge after imem_rvalid. Full/stop hold the outputs, with one spare pair in pending.
// Optional IF_PREDECODE_EN: static JAL / backward-branch prediction on captured slots.
module if_fetch2 #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              instbuf_full,
  input  logic              branch_flag,
  input  logic [PC_W-1:0]   branch_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [63:0]       imem_rdata,
  output logic              out1_valid,
  output logic [INST_W-1:0] out1_inst,
  output logic [PC_W-1:0]   out1_pc,
  output logic [PC_W-1:0]   out1_npc,
  output logic              out2_valid,
  output logic [INST_W-1:0] out2_inst,
  output logic [PC_W-1:0]   out2_pc,
  output logic [PC_W-1:0]   out2_npc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic              drop;
  logic              pend_valid, pend2_valid;
  logic [INST_W-1:0] pend1_inst, pend2_inst;
  logic [PC_W-1:0]   pend1_pc, pend1_npc, pend2_pc, pend2_npc;

  logic              consume;
  logic [INST_W-1:0] s1_inst, s2_inst;
  logic [PC_W-1:0]   s1_pc, s1_npc, s2_pc, s2_npc, nxt_pc;
  logic              s2_vld;

  assign consume   = out1_valid && !instbuf_full && !stop;
  assign imem_req  = rst && (state == S_REQ) && !stop && !branch_flag;
  assign imem_addr = {pc[PC_W-1:3], 3'b000};

`ifdef IF_PREDECODE_EN
  // Returns {taken, target}: JAL always, conditional branches only when backward.
  function automatic logic [PC_W:0] predict(input logic [INST_W-1:0] inst, input logic [PC_W-1:0] ipc);
    logic [20:0] jimm;
    logic [12:0] bimm;
    jimm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    bimm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    predict = '0;
    if (inst[6:0] == 7'b1101111)
      predict = {1'b1, ipc + {{(PC_W-21){jimm[20]}}, jimm}};
    else if (inst[6:0] == 7'b1100011 && inst[31])
      predict = {1'b1, ipc + {{(PC_W-13){bimm[12]}}, bimm}};
  endfunction
`endif

  always_comb begin
    s1_inst = pc[2] ? imem_rdata[32 +: INST_W] : imem_rdata[INST_W-1:0];
    s1_pc   = pc;
    s1_npc  = pc + PC_W'(4);
    s2_vld  = !pc[2];
    s2_inst = imem_rdata[32 +: INST_W];
    s2_pc   = pc + PC_W'(4);
    s2_npc  = pc + PC_W'(8);
    nxt_pc  = pc[2] ? pc + PC_W'(4) : pc + PC_W'(8);
`ifdef IF_PREDECODE_EN
    begin
      logic [PC_W:0] p1, p2;
      p1 = predict(s1_inst, s1_pc);
      p2 = predict(s2_inst, s2_pc);
      if (p1[PC_W]) begin
        s1_npc = p1[PC_W-1:0];
        s2_vld = 1'b0;
        nxt_pc = p1[PC_W-1:0];
      end else if (s2_vld && p2[PC_W]) begin
        s2_npc = p2[PC_W-1:0];
        nxt_pc = p2[PC_W-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      pend_valid  <= 1'b0;
      pend2_valid <= 1'b0;
      pend1_inst  <= '0;
      pend1_pc    <= '0;
      pend1_npc   <= '0;
      pend2_inst  <= '0;
      pend2_pc    <= '0;
      pend2_npc   <= '0;
      out1_valid  <= 1'b0;
      out1_inst   <= '0;
      out1_pc     <= '0;
      out1_npc    <= '0;
      out2_valid  <= 1'b0;
      out2_inst   <= '0;
      out2_pc     <= '0;
      out2_npc    <= '0;
    end else if (branch_flag) begin
      out1_valid <= 1'b0;
      out2_valid <= 1'b0;
      pend_valid <= 1'b0;
      pc         <= {branch_pc[PC_W-1:2], 2'b00};
      // An in-flight request whose data has not arrived yet must be swallowed later.
      if (state == S_WAIT && !imem_rvalid) begin
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= S_REQ;
      end
    end else begin
      if (consume) begin
        out1_valid <= 1'b0;
        out2_valid <= 1'b0;
      end
      case (state)
        S_REQ: if (imem_req && imem_ready) state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid && drop) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else if (imem_rvalid) begin
            pc <= nxt_pc;
            if (!out1_valid || consume) begin
              out1_valid <= 1'b1;
              out1_inst  <= s1_inst;
              out1_pc    <= s1_pc;
              out1_npc   <= s1_npc;
              out2_valid <= s2_vld;
              out2_inst  <= s2_inst;
              out2_pc    <= s2_pc;
              out2_npc   <= s2_npc;
              state      <= S_REQ;
            end else begin
              pend_valid  <= 1'b1;
              pend1_inst  <= s1_inst;
              pend1_pc    <= s1_pc;
              pend1_npc   <= s1_npc;
              pend2_valid <= s2_vld;
              pend2_inst  <= s2_inst;
              pend2_pc    <= s2_pc;
              pend2_npc   <= s2_npc;
              state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            out1_valid <= pend_valid;
            out1_inst  <= pend1_inst;
            out1_pc    <= pend1_pc;
            out1_npc   <= pend1_npc;
            out2_valid <= pend_valid && pend2_valid;
            out2_inst  <= pend2_inst;
            out2_pc    <= pend2_pc;
            out2_npc   <= pend2_npc;
            pend_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
